// File: rtl/fifo_wr_src.sv
// fifo_wr_src: frame-aware write source for the write side of an async FIFO.
// Upstream beats pass through a 2-entry in-order buffer and are written as
// {last, data}. The enable is honoured on frame boundaries: dropping en
// mid-frame lets the current frame finish (DRAIN) before going idle.
// Optional feature: define FIFO_WR_SRC_STALL_EN to add the stall_cnt output.
module fifo_wr_src #(
  parameter int unsigned DW    = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic             en,
  input  logic             s_valid,
  input  logic [DW-1:0]    s_data,
  input  logic             s_last,
  output logic             s_ready,
  input  logic             wfull,
  output logic             winc,
  output logic [DW:0]      wdata,
  output logic             busy,
  output logic [CNT_W-1:0] frames
`ifdef FIFO_WR_SRC_STALL_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StActive, StDrain} state_e;

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             in_frame_q, in_frame_d;
  logic [DW:0]      buf0_q, buf0_d;  // head entry
  logic [DW:0]      buf1_q, buf1_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic             push, pop;
  logic [DW:0]      word;

  // Handshake outputs depend only on flops (plus wfull for the write strobe).
  always_comb begin
    s_ready = (cnt_q != 2'd2) &&
              ((state_q == StActive) || ((state_q == StDrain) && in_frame_q));
    winc    = (cnt_q != 2'd0) && !wfull && (state_q != StIdle);
    wdata   = buf0_q;
    busy    = (state_q != StIdle);
    frames  = frames_q;
    push    = s_valid && s_ready;
    pop     = winc;
    word    = {s_last, s_data};
  end

  // Buffer update: pop shifts the tail into the head, push appends in order.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) buf0_d = word;
        else               buf1_d = word;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          buf0_d = word;
        end else begin
          buf0_d = buf1_q;
          buf1_d = word;
        end
      end
      default: ;
    endcase
  end

  // Frame tracking, frame counter and state transitions.
  always_comb begin
    in_frame_d = push ? !s_last : in_frame_q;
    frames_d   = frames_q;
    if (winc && buf0_q[DW]) frames_d = frames_q + 1'b1;
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (en) state_d = StActive;
      StActive: begin
        if (!en) begin
          state_d = (!in_frame_d && (cnt_d == 2'd0)) ? StIdle : StDrain;
        end
      end
      StDrain: begin
        if (en)                                     state_d = StActive;
        else if (!in_frame_d && (cnt_d == 2'd0))    state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset discards any buffered beats.
  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      state_q    <= StIdle;
      cnt_q      <= 2'd0;
      in_frame_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      frames_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_frame_q <= in_frame_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      frames_q   <= frames_d;
    end
  end

`ifdef FIFO_WR_SRC_STALL_EN
  logic [CNT_W-1:0] stall_q, stall_d;

  // Count cycles where a beat is pending but the FIFO is full; saturate.
  always_comb begin
    stall_d = stall_q;
    if ((cnt_q != 2'd0) && wfull && (state_q != StIdle) && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
    stall_cnt = stall_q;
  end

  // Stall counter register.
  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) stall_q <= '0;
    else       stall_q <= stall_d;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_src.sv
// tb_fifo_wr_src: randomized and directed bench for fifo_wr_src against a
// queue-based reference model. Outputs are checked 1 ns after the falling edge.
module tb_fifo_wr_src;

  localparam int unsigned DW    = 8;
  localparam int unsigned CNT_W = 4;
  localparam int          MOD   = 1 << CNT_W;
  localparam int          MIdle = 0, MActive = 1, MDrain = 2;

  logic             wclk = 1'b0;
  logic             wrst;
  logic             en, s_valid, s_last, s_ready, wfull, winc, busy;
  logic [DW-1:0]    s_data;
  logic [DW:0]      wdata;
  logic [CNT_W-1:0] frames;
`ifdef FIFO_WR_SRC_STALL_EN
  logic [CNT_W-1:0] stall_cnt;
`endif

  fifo_wr_src #(.DW(DW), .CNT_W(CNT_W)) dut (
    .wclk     (wclk),
    .wrst     (wrst),
    .en       (en),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .wfull    (wfull),
    .winc     (winc),
    .wdata    (wdata),
    .busy     (busy),
    .frames   (frames)
`ifdef FIFO_WR_SRC_STALL_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 wclk = ~wclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [DW:0] q[$];
  int          m_st;
  logic        m_inf;
  int          m_frames;
  int          m_stall;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_st     = MIdle;
    m_inf    = 1'b0;
    m_frames = 0;
    m_stall  = 0;
  endtask

  // One clock cycle: apply inputs, compare against the model, then advance it.
  task automatic step(input logic e, input logic v, input logic [DW-1:0] d, input logic l,
                      input logic wf);
    logic m_ready, m_winc, acc;
    int   sz;
    @(negedge wclk);
    en = e; s_valid = v; s_data = d; s_last = l; wfull = wf;
    #1;
    m_ready = (q.size() < 2) && (m_st == MActive || (m_st == MDrain && m_inf));
    m_winc  = (q.size() != 0) && !wf && (m_st != MIdle);
    check_eq("s_ready", 32'(s_ready), 32'(m_ready));
    check_eq("winc", 32'(winc), 32'(m_winc));
    check_eq("busy", 32'(busy), 32'(m_st != MIdle));
    check_eq("frames", 32'(frames), 32'(m_frames));
    if (q.size() != 0) check_eq("wdata", 32'(wdata), 32'(q[0]));
`ifdef FIFO_WR_SRC_STALL_EN
    check_eq("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    @(posedge wclk);
    sz  = q.size();
    acc = v && m_ready;
    if (m_winc) begin
      if (q[0][DW]) m_frames = (m_frames + 1) % MOD;
      q.delete(0);
    end
    if (sz != 0 && wf && m_st != MIdle && m_stall < MOD - 1) m_stall++;
    if (acc) begin
      q.push_back({l, d});
      m_inf = !l;
    end
    case (m_st)
      MIdle:   if (e) m_st = MActive;
      MActive: if (!e) m_st = (!m_inf && q.size() == 0) ? MIdle : MDrain;
      default: begin
        if (e) m_st = MActive;
        else if (!m_inf && q.size() == 0) m_st = MIdle;
      end
    endcase
  endtask

  // Asynchronous reset pulse; outputs must clear immediately.
  task automatic pulse_reset();
    @(negedge wclk);
    en = 1'b0; s_valid = 1'b0; wfull = 1'b0;
    #2 wrst = 1'b0;
    #1;
    check_eq("rst_s_ready", 32'(s_ready), 32'd0);
    check_eq("rst_winc", 32'(winc), 32'd0);
    check_eq("rst_wdata", 32'(wdata), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_frames", 32'(frames), 32'd0);
`ifdef FIFO_WR_SRC_STALL_EN
    check_eq("rst_stall", 32'(stall_cnt), 32'd0);
`endif
    model_clear();
    @(negedge wclk);
    wrst = 1'b1;
  endtask

  initial begin
    wrst = 1'b0; en = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; wfull = 1'b0;
    model_clear();
    #12;
    check_eq("init_winc", 32'(winc), 32'd0);
    check_eq("init_busy", 32'(busy), 32'd0);
    check_eq("init_wdata", 32'(wdata), 32'd0);
    @(negedge wclk);
    wrst = 1'b1;

    // Three back-to-back beats, last one ends the frame.
    step(1, 0, 8'h00, 0, 0);
    step(1, 1, 8'h11, 0, 0);
    step(1, 1, 8'h22, 0, 0);
    step(1, 1, 8'h33, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 0, 0);
    check_eq("frames_after_3beats", 32'(frames), 32'd1);

    // FIFO full for 5 cycles with beats offered, then released.
    pulse_reset();
    step(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 8'(8'h50 + i), 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 0, 0);

    // en dropped mid-frame: frame completes in DRAIN, then idle.
    pulse_reset();
    step(1, 0, 8'h00, 0, 0);
    step(1, 1, 8'hA0, 0, 0);
    step(0, 1, 8'hA1, 0, 0);
    step(0, 1, 8'hA2, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 8'hA3, 0, 0);
    check_eq("drain_idle_busy", 32'(busy), 32'd0);

    // Reset with two beats buffered mid-frame; nothing written until en.
    pulse_reset();
    step(1, 0, 8'h00, 0, 0);
    step(1, 1, 8'hC0, 0, 1);
    step(1, 1, 8'hC1, 0, 1);
    pulse_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 8'hC2, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    step(1, 1, 8'hC3, 1, 0);
    step(1, 0, 8'h00, 0, 0);

    // 17 single-beat frames wrap a 4-bit frame counter back to 1.
    pulse_reset();
    step(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 17; i++) step(1, 1, 8'(i), 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 0, 0);
    check_eq("frames_wrap", 32'(frames), 32'd1);

    // Randomized traffic with an occasional mid-run reset.
    pulse_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) pulse_reset();
      step(logic'(($urandom_range(0, 15) > 2) || (i % 200 < 150 && i % 200 > 100)),
           logic'($urandom_range(0, 3) != 0), 8'($urandom),
           logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 3) == 0));
    end
    // Long full stretch to exercise counter saturation.
    step(1, 1, 8'h77, 0, 1);
    for (int i = 0; i < 20; i++) step(1, 1, 8'h78, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 8'h00, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
